regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised successor to the core register file: NUM_REGS x DATA_W storage with two combinational read ports, one synchronous write port, register 0 hardwired to zero, and a per-register busy scoreboard. Sits between decode/issue and writeback. Issue reserves a destination register, which marks it busy. Writeback writes data and releases the reservation. Decode reads operands and busy flags to detect RAW and WAW hazards.

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of registers; power of two, >= 2
- ADDR_W, $clog2(NUM_REGS), register address width; derived, not overridden
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- rd_addr_1, rd_addr_2  input  ADDR_W  read port addresses
- rd_data_1, rd_data_2  output  DATA_W  read data
- rd_busy_1, rd_busy_2  output  1  busy flag of addressed register
- wr_en  input  1  write strobe
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- rsv_en  input  1  reserve request from issue
- rsv_addr  input  ADDR_W  register to reserve
- rsv_ok  output  1  reserve accepted this cycle (combinational)
- busy_count  output  ADDR_W+1  number of busy registers

## Operation
- Storage is `regs[NUM_REGS]` plus `busy[NUM_REGS]`, all flops.
- While reset is low, every `regs` entry, every `busy` bit and `busy_count` are 0.
  - Outputs during reset: rd_data_* = 0, rd_busy_* = 0, rsv_ok = rsv_en && rsv_addr != 0.
- Register 0:
  - reads always return 0 with busy 0;
  - writes to it are dropped;
  - reserving it gives rsv_ok = 1 with no state change.
- Write: when wr_en is high at a clk edge and wr_addr != 0, then `regs[wr_addr] <= wr_data` and `busy[wr_addr] <= 0`.
- Reserve: `rsv_ok = rsv_en && (rsv_addr == 0 || !busy_eff[rsv_addr])`.
  - `busy_eff` is the busy bit after any same-cycle release by a write.
  - When rsv_ok is high and rsv_addr != 0, then `busy[rsv_addr] <= 1`.
  - A rejected reserve (WAW conflict) changes no state; issue must hold and retry.
- Simultaneous write and reserve to the same nonzero register:
  - the write lands;
  - the release is honoured, so the reserve is accepted;
  - `busy` ends at 1, because the new producer owns the register.
- Write to a non-busy register is legal: data updates and busy stays 0.
- busy_count is the registered population count of `busy`, updated every edge.
  - Net change per cycle is in {-1, 0, +1}.
  - Range is 0 to NUM_REGS-1; it never wraps.

## Timing
- Reads are combinational from current state, or bypassed (see Configuration).
- Write data is visible from the cycle after the edge.
- rsv_ok has zero latency. The busy bit sets at the same edge.
- Release-to-reissue: a write in cycle N permits an accepted reserve in the same cycle N.
- Reset asserted mid-operation immediately clears all state.
  - The first edge after deassertion is a normal edge.

## Configuration
- REGFILE_BYPASS_EN defined:
  - if wr_en && wr_addr == rd_addr_x && rd_addr_x != 0, then rd_data_x = wr_data;
  - rd_busy_x = 1 only when a same-cycle accepted reserve targets that register, otherwise 0;
  - this gives same-cycle writeback-to-decode forwarding.
- REGFILE_BYPASS_EN undefined:
  - reads return stored `regs` and `busy` only;
  - a same-cycle write is seen the next cycle.
- Register-0 rules and rsv_ok logic are identical in both builds.

## Test plan
- Reset and register 0:
  - hold reset low and drive random writes: all reads = 0 and busy_count = 0;
  - after release, write 0xDEADBEEF to reg 0, then read reg 0: reads 0.
- Basic write/read:
  - write 0x12345678 to r5, then read r5 on both ports next cycle: 0x12345678 on both, busy 0.
- Scoreboard:
  - reserve r7: rsv_ok = 1, next cycle rd_busy(r7) = 1 and busy_count = 1;
  - reserve r7 again: rsv_ok = 0, state unchanged;
  - write r7 = 0xA5: busy clears and busy_count = 0.
- Simultaneous events:
  - with r3 busy, write r3 = 0x55 and reserve r3 in the same cycle: rsv_ok = 1, next cycle r3 = 0x55, busy(r3) = 1, busy_count unchanged.
- Bypass, run in both builds:
  - write r9 = 0xCAFE while reading r9 in the same cycle;
  - with REGFILE_BYPASS_EN: rd_data = 0xCAFE in that cycle;
  - without: old value in that cycle, 0xCAFE the next cycle.
- Full scoreboard:
  - reserve r1 to r31 one per cycle: busy_count reaches 31;
  - assert reset low mid-sequence: busy_count = 0 immediately and all rd_busy = 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard: two combinational read ports, one write port, r0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data (and reserve state) onto the read ports.
module regfile_sb #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              rd_busy_1,
  output logic              rd_busy_2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  output logic [ADDR_W:0]   busy_count
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [ADDR_W:0]     r_busy_count;

  logic                w_wr_nz;
  logic                w_busy_eff;
  logic                w_set;
  logic                w_rel;
  logic [NUM_REGS-1:0] w_busy_nxt;

  assign w_wr_nz    = wr_en && (wr_addr != '0);
  // A same-cycle write releases the target before the reserve looks at it.
  assign w_busy_eff = r_busy[rsv_addr] && !(w_wr_nz && (wr_addr == rsv_addr));
  // r0 reserve is always granted outside reset, never inside it.
  assign rsv_ok     = rsv_en && ((rsv_addr == '0) ? reset : !w_busy_eff);
  assign w_set      = rsv_ok && (rsv_addr != '0);
  assign w_rel      = w_wr_nz && r_busy[wr_addr];

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_nz) w_busy_nxt[wr_addr] = 1'b0;
    if (w_set)   w_busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      if (w_wr_nz) r_regs[wr_addr] <= wr_data;
      r_busy       <= w_busy_nxt;
      // Same-register write+reserve gives set=rel=1, so the count nets to zero.
      r_busy_count <= r_busy_count + {{ADDR_W{1'b0}}, w_set} - {{ADDR_W{1'b0}}, w_rel};
    end
  end

  assign busy_count = r_busy_count;

`ifdef REGFILE_BYPASS_EN
  assign rd_data_1 = (!reset || rd_addr_1 == '0) ? '0 :
                     (w_wr_nz && wr_addr == rd_addr_1) ? wr_data : r_regs[rd_addr_1];
  assign rd_data_2 = (!reset || rd_addr_2 == '0) ? '0 :
                     (w_wr_nz && wr_addr == rd_addr_2) ? wr_data : r_regs[rd_addr_2];
  // On a forwarded write the register is busy only if a new producer claims it this cycle.
  assign rd_busy_1 = (!reset || rd_addr_1 == '0) ? 1'b0 :
                     (w_wr_nz && wr_addr == rd_addr_1) ? (w_set && rsv_addr == rd_addr_1) :
                     r_busy[rd_addr_1];
  assign rd_busy_2 = (!reset || rd_addr_2 == '0) ? 1'b0 :
                     (w_wr_nz && wr_addr == rd_addr_2) ? (w_set && rsv_addr == rd_addr_2) :
                     r_busy[rd_addr_2];
`else
  assign rd_data_1 = (!reset || rd_addr_1 == '0) ? '0 : r_regs[rd_addr_1];
  assign rd_data_2 = (!reset || rd_addr_2 == '0) ? '0 : r_regs[rd_addr_2];
  assign rd_busy_1 = (!reset || rd_addr_1 == '0) ? 1'b0 : r_busy[rd_addr_1];
  assign rd_busy_2 = (!reset || rd_addr_2 == '0) ? 1'b0 : r_busy[rd_addr_2];
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, r0 rules, write/read, scoreboard, simultaneous events, bypass, full scoreboard.
`timescale 1ns/1ps
module tb_regfile_sb;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] rd_addr_1, rd_addr_2, wr_addr, rsv_addr;
  logic [DATA_W-1:0] rd_data_1, rd_data_2, wr_data;
  logic              rd_busy_1, rd_busy_2, wr_en, rsv_en, rsv_ok;
  logic [ADDR_W:0]   busy_count;

  int n_checks = 0;
  int n_errors = 0;

  regfile_sb #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .reset(reset),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .rd_busy_1(rd_busy_1), .rd_busy_2(rd_busy_2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  initial begin
    reset = 1'b0;
    rd_addr_1 = '0; rd_addr_2 = '0;
    idle();
    tick();
    // reset held: writes and reserves are ignored, outputs are zero
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = $urandom;
      rsv_en = 1'b1; rsv_addr = ADDR_W'(i + 4);
      rd_addr_1 = ADDR_W'(i); rd_addr_2 = ADDR_W'(i + 4);
      #1;
      chk("rst_rd1", rd_data_1, 0);
      chk("rst_busy2", rd_busy_2, 0);
      chk("rst_rsv_ok", rsv_ok, 1);
      chk("rst_cnt", busy_count, 0);
      tick();
    end
    rsv_addr = '0;
    #1;
    chk("rst_rsv0", rsv_ok, 0);
    idle();
    reset = 1'b1;
    rd_addr_1 = 5'd1; rd_addr_2 = 5'd5;
    #1;
    chk("post_rst_r1", rd_data_1, 0);
    chk("post_rst_busy", rd_busy_2, 0);
    rsv_en = 1'b1; rsv_addr = '0;
    #1;
    chk("rsv_r0_ok", rsv_ok, 1);
    tick();
    chk("rsv_r0_cnt", busy_count, 0);

    // r0 writes are dropped
    idle();
    wr_en = 1'b1; wr_addr = '0; wr_data = 32'hDEADBEEF;
    tick();
    idle();
    rd_addr_1 = '0; rd_addr_2 = '0;
    #1;
    chk("r0_rd1", rd_data_1, 0);
    chk("r0_rd2", rd_data_2, 0);
    chk("r0_busy", rd_busy_1, 0);

    // basic write/read
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678;
    rd_addr_1 = 5'd5; rd_addr_2 = 5'd5;
    tick();
    idle();
    #1;
    chk("r5_rd1", rd_data_1, 32'h12345678);
    chk("r5_rd2", rd_data_2, 32'h12345678);
    chk("r5_busy", rd_busy_1, 0);

    // scoreboard reserve / WAW reject / release
    rd_addr_1 = 5'd7; rd_addr_2 = 5'd5;
    rsv_en = 1'b1; rsv_addr = 5'd7;
    #1;
    chk("rsv7_ok", rsv_ok, 1);
    tick();
    chk("r7_busy", rd_busy_1, 1);
    chk("r5_notbusy", rd_busy_2, 0);
    chk("cnt_1", busy_count, 1);
    chk("rsv7_again", rsv_ok, 0);
    tick();
    chk("r7_still_busy", rd_busy_1, 1);
    chk("cnt_still_1", busy_count, 1);
    idle();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5;
    tick();
    idle();
    #1;
    chk("r7_data", rd_data_1, 32'hA5);
    chk("r7_released", rd_busy_1, 0);
    chk("cnt_0", busy_count, 0);

    // simultaneous write + reserve on busy r3
    rd_addr_1 = 5'd3; rd_addr_2 = 5'd10;
    rsv_en = 1'b1; rsv_addr = 5'd3;
    tick();
    chk("cnt_r3", busy_count, 1);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    #1;
    chk("rsv3_reissue_ok", rsv_ok, 1);
    tick();
    idle();
    #1;
    chk("r3_data", rd_data_1, 32'h55);
    chk("r3_busy", rd_busy_1, 1);
    chk("cnt_r3_same", busy_count, 1);
    // release r3 and reserve r10 in one cycle
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h66;
    rsv_en = 1'b1; rsv_addr = 5'd10;
    #1;
    chk("rsv10_ok", rsv_ok, 1);
    tick();
    idle();
    #1;
    chk("r3_free", rd_busy_1, 0);
    chk("r10_busy", rd_busy_2, 1);
    chk("cnt_swap", busy_count, 1);
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h10;
    tick();
    idle();
    #1;
    chk("cnt_clear", busy_count, 0);

    // same-cycle write/read of r9
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1111;
    tick();
    wr_data = 32'hCAFE;
    rd_addr_1 = 5'd9; rd_addr_2 = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_same", rd_data_1, 32'hCAFE);
`else
    chk("byp_same", rd_data_1, 32'h1111);
`endif
    chk("byp_busy", rd_busy_2, 0);
    tick();
    idle();
    #1;
    chk("byp_next", rd_data_2, 32'hCAFE);

    // partial scoreboard fill then reset mid-cycle
    for (int a = 1; a <= 20; a++) begin
      rsv_en = 1'b1; rsv_addr = ADDR_W'(a);
      #1;
      chk("fill_ok", rsv_ok, 1);
      tick();
    end
    idle();
    rd_addr_1 = 5'd1; rd_addr_2 = 5'd20;
    #1;
    chk("cnt_20", busy_count, 20);
    chk("busy_r20", rd_busy_2, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_cnt", busy_count, 0);
    chk("mid_rst_busy1", rd_busy_1, 0);
    chk("mid_rst_busy2", rd_busy_2, 0);
    rd_addr_1 = 5'd9;
    #1;
    chk("mid_rst_data", rd_data_1, 0);
    tick();
    reset = 1'b1;
    // first edge after release is a normal edge
    rsv_en = 1'b1; rsv_addr = 5'd2;
    rd_addr_1 = 5'd2;
    tick();
    chk("first_edge_busy", rd_busy_1, 1);
    chk("first_edge_cnt", busy_count, 1);

    // full scoreboard: r2 is already held, so its reserve is rejected
    for (int a = 1; a <= 31; a++) begin
      rsv_en = 1'b1; rsv_addr = ADDR_W'(a);
      #1;
      chk("full_ok", rsv_ok, (a != 2) ? 1 : 0);
      tick();
    end
    idle();
    rd_addr_1 = 5'd31; rd_addr_2 = 5'd1;
    #1;
    chk("cnt_31", busy_count, 31);
    chk("busy_r31", rd_busy_1, 1);
    chk("busy_r1", rd_busy_2, 1);
    rsv_en = 1'b1; rsv_addr = 5'd31;
    #1;
    chk("full_rsv31_rej", rsv_ok, 0);
    tick();
    chk("cnt_31_hold", busy_count, 31);
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
